dmem_responder: RTL

Data-memory responder sitting at the far end of the EX/MEM pipeline register. It accepts one load or store per request from the MEM stage and performs RISC-V byte/half/word access against an internal word-organised RAM. It returns sign- or zero-extended load data, or a fault for misaligned or illegal accesses. While an access is in flight it drives `stall` so the hazard logic freezes the pipeline.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 76 +++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the MEM stage and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, stall, resp_valid, resp_rdata, resp_fault
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, stall, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: RISC-V byte/half/word data memory with fixed-latency response and stall
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH+1:0] addr_q, a_addr;
  logic [31:0]           wdata_q, a_wdata, wlane, word, shifted, rdata;
  logic [2:0]            f3_q, a_f3;
  logic                  wr_q, a_wr, accept, go, fault;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  unused_addr;
  assign unused_addr   = ^bus.req_addr[31:ADDR_WIDTH+2];
  assign bus.req_ready = state == IDLE;
  assign bus.stall     = state != IDLE;
  assign accept        = bus.req_valid & bus.req_ready;
  // with single-cycle latency the access happens on the accepting edge straight off the bus
  assign go = LATENCY == 1 ? accept : state == BUSY && cnt == 3'd1;
  always_comb begin
    a_addr  = LATENCY == 1 ? bus.req_addr[ADDR_WIDTH+1:0] : addr_q;
    a_wdata = LATENCY == 1 ? bus.req_wdata : wdata_q;
    a_f3    = LATENCY == 1 ? bus.req_funct3 : f3_q;
    a_wr    = LATENCY == 1 ? bus.req_write : wr_q;
    off     = a_addr[1:0];
    idx     = a_addr[ADDR_WIDTH+1:2];
    fault   = a_f3[1:0] == 2'b11 || a_f3 == 3'b110 || (a_wr && a_f3[2]) ||
              (a_f3[1:0] == 2'b01 && off[0]) || (a_f3[1:0] == 2'b10 && off != 2'b00);
    be      = a_f3[1:0] == 2'b00 ? 4'b0001 << off : a_f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wlane   = a_f3[1:0] == 2'b00 ? {4{a_wdata[7:0]}} : a_f3[1:0] == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
    word    = mem[idx];
    shifted = word >> {off, 3'b000};
    rdata   = a_f3[1:0] == 2'b00 ? {{24{!a_f3[2] && shifted[7]}}, shifted[7:0]} :
              a_f3[1:0] == 2'b01 ? {{16{!a_f3[2] && shifted[15]}}, shifted[15:0]} : word;
  end
  always_ff @(posedge clk)
    if (!reset && go && a_wr && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_fault <= 1'b0;
    end else begin
      bus.resp_valid <= go;
      if (go) begin
        bus.resp_rdata <= (fault || a_wr) ? '0 : rdata;
        bus.resp_fault <= fault;
      end
      if (accept) begin
        addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
        wr_q    <= bus.req_write;
        if (LATENCY > 1) begin
          state <= BUSY;
          cnt   <= 3'(LATENCY - 1);
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) state <= IDLE;
      end
    end
  end
endmodule
